pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Stall/flush scheduler for the 6-stage pipeline (IF, ID, RR, EX, MEM, WB). It compares the source-register fields produced by the instruction decoder in ID against the destinations of loads in RR and EX, and inserts load-use stall cycles. It also sequences pipeline flushes for taken branches and jumps. Its outputs gate the PC and IF/ID enables, inject a bubble into ID/RR, and clear the front-end pipeline registers.

## Interface
- No parameters.
- clk  in  1  pipeline clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_src1, id_src2  in  4 each  decoder source fields: [3] = register read used, [2:0] = register index
- id_jal  in  1  JAL decoded in ID this cycle
- rr_valid, ex_valid  in  1 each  RR/EX stage occupied
- rr_dest, ex_dest  in  3 each  destination index of the RR/EX instruction
- rr_wb_en, ex_wb_en  in  1 each  WB[2] of the RR/EX instruction
- rr_mem_rd, ex_mem_rd  in  1 each  Memory[1] (load) of the RR/EX instruction
- ex_br_taken  in  1  BEQ taken or JLR resolved in EX
- pc_en  out  1  PC update enable
- ifid_en  out  1  IF/ID register load enable
- idrr_bubble  out  1  load a NOP into ID/RR
- flush_ifid, flush_idrr, flush_rrex  out  1 each  clear the corresponding pipeline register
- ctrl_state  out  2  00 RUN, 01 STALL, 10 FLUSH

## Operation
- match(S, N) = id_valid & id_srcN[3] & S_valid & S_wb_en & S_mem_rd & (id_srcN[2:0] == S_dest), for S in {rr, ex} and N in {1, 2}.
- haz_rr = match(rr,1) | match(rr,2). haz_ex = match(ex,1) | match(ex,2).
- RUN:
  - ex_br_taken: assert flush_ifid, flush_idrr, flush_rrex; go to FLUSH.
  - else haz_rr: pc_en=0, ifid_en=0, idrr_bubble=1; go to STALL (2 stall cycles total).
  - else haz_ex: the same stall outputs for this cycle only; stay in RUN (1 stall cycle).
  - else id_jal: flush_ifid=1; stay in RUN.
  - else: pc_en=1, ifid_en=1, all other outputs 0.
- STALL:
  - ex_br_taken: the flush has priority and aborts the stall; assert all three flushes; go to FLUSH.
  - else: pc_en=0, ifid_en=0, idrr_bubble=1; go to RUN. id_jal is ignored because ID is held.
- FLUSH: flush_ifid=1 (the stale fetch from before the redirect), pc_en=1, ifid_en=1; go to RUN unconditionally. A second ex_br_taken here is impossible because EX holds a bubble; it is ignored.
- Hazard detection never matches when the src valid bit [3]=0, so don't-care fields from the decoder are safe.
- Register index 0–7 is compared as plain 3-bit equality; there is no special case for R7.

## Timing
- Outputs are combinational from ctrl_state and the inputs. ctrl_state is registered.
- Load in RR with a dependent instruction in ID: stall in cycle N (detection) and N+1. The consumer leaves ID at the end of N+2's edge sequence, i.e. it is released in cycle N+2.
- Load in EX with a dependent instruction: stall in cycle N only.
- Taken branch in cycle N: three flushes in N, flush_ifid again in N+1, normal issue from N+2.
- Reset (synchronous): ctrl_state ← RUN (00). While reset=1, outputs are forced: pc_en=0, ifid_en=0, idrr_bubble=0, flush_ifid=flush_idrr=flush_rrex=1. Reset mid-STALL or mid-FLUSH takes effect in the same cycle and returns to RUN.

## Configuration
- PIPE_HAZARD_PERF_EN defined: adds outputs stall_cycles[15:0] and flush_events[15:0].
  - stall_cycles increments on every cycle with idrr_bubble=1.
  - flush_events increments on every cycle with ex_br_taken=1.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: neither port nor counter exists. All other behaviour is identical.

## Test plan
- LW R3 in RR (rr_dest=3, rr_mem_rd=1, rr_wb_en=1), id_src1=4'b1011 -> pc_en=0 and idrr_bubble=1 for 2 cycles, ctrl_state 00→01→00.
- Same load in EX, id_src2=4'b1011 -> exactly 1 stall cycle; ctrl_state stays 00.
- id_src1=4'b0011 against the RR load of R3 -> no stall, pc_en=1.
- ex_br_taken=1 in the STALL cycle -> flush_ifid/flush_idrr/flush_rrex=1, ctrl_state 01→10→00, flush_ifid=1 in the FLUSH cycle.
- id_jal=1 in RUN with no hazard -> flush_ifid=1 for 1 cycle, pc_en=1; id_jal=1 during STALL -> flush_ifid=0.
- reset=1 asserted while in FLUSH -> next state 00; during reset pc_en=0 and all flushes=1. With PIPE_HAZARD_PERF_EN, counters read 0 after reset and 2 after one RR load-use stall.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: decoder/stage hazard inputs and pipeline control outputs (PIPE_HAZARD_PERF_EN adds counters)
interface pipe_hazard_ctrl_if;
    logic       id_valid;
    logic [3:0] id_src1;
    logic [3:0] id_src2;
    logic       id_jal;
    logic       rr_valid;
    logic       ex_valid;
    logic [2:0] rr_dest;
    logic [2:0] ex_dest;
    logic       rr_wb_en;
    logic       ex_wb_en;
    logic       rr_mem_rd;
    logic       ex_mem_rd;
    logic       ex_br_taken;
    logic       pc_en;
    logic       ifid_en;
    logic       idrr_bubble;
    logic       flush_ifid;
    logic       flush_idrr;
    logic       flush_rrex;
    logic [1:0] ctrl_state;
`ifdef PIPE_HAZARD_PERF_EN
    logic [15:0] stall_cycles;
    logic [15:0] flush_events;
`endif

    modport master (
        output id_valid, id_src1, id_src2, id_jal, rr_valid, ex_valid, rr_dest, ex_dest,
               rr_wb_en, ex_wb_en, rr_mem_rd, ex_mem_rd, ex_br_taken,
`ifdef PIPE_HAZARD_PERF_EN
        input  stall_cycles, flush_events,
`endif
        input  pc_en, ifid_en, idrr_bubble, flush_ifid, flush_idrr, flush_rrex, ctrl_state
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_jal, rr_valid, ex_valid, rr_dest, ex_dest,
               rr_wb_en, ex_wb_en, rr_mem_rd, ex_mem_rd, ex_br_taken,
`ifdef PIPE_HAZARD_PERF_EN
        output stall_cycles, flush_events,
`endif
        output pc_en, ifid_en, idrr_bubble, flush_ifid, flush_idrr, flush_rrex, ctrl_state
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stall and branch/jump flush scheduler for the 6-stage pipeline (PIPE_HAZARD_PERF_EN adds counters)
module pipe_hazard_ctrl (
    input  logic                    clk,
    input  logic                    reset,
    pipe_hazard_ctrl_if.slave       bus
);
    typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, FLUSH = 2'b10} state_t;

    state_t state;
    state_t nxt;
    logic   haz_rr;
    logic   haz_ex;
    logic   pc_en;
    logic   ifid_en;
    logic   bubble;
    logic   f_ifid;
    logic   f_idrr;
    logic   f_rrex;

    // load-use match of either used source against a load destination in RR or EX
    always_comb begin
        haz_rr = bus.id_valid & bus.rr_valid & bus.rr_wb_en & bus.rr_mem_rd &
                 ((bus.id_src1[3] & (bus.id_src1[2:0] == bus.rr_dest)) |
                  (bus.id_src2[3] & (bus.id_src2[2:0] == bus.rr_dest)));
        haz_ex = bus.id_valid & bus.ex_valid & bus.ex_wb_en & bus.ex_mem_rd &
                 ((bus.id_src1[3] & (bus.id_src1[2:0] == bus.ex_dest)) |
                  (bus.id_src2[3] & (bus.id_src2[2:0] == bus.ex_dest)));
    end

    // control outputs and next state; reset forces a front-end clear, a pending redirect beats any stall
    always_comb begin
        nxt     = RUN;
        pc_en   = 1'b1;
        ifid_en = 1'b1;
        bubble  = 1'b0;
        f_ifid  = 1'b0;
        f_idrr  = 1'b0;
        f_rrex  = 1'b0;
        if (reset) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            f_ifid  = 1'b1;
            f_idrr  = 1'b1;
            f_rrex  = 1'b1;
        end else if (state == FLUSH) begin
            f_ifid  = 1'b1;
        end else if (bus.ex_br_taken) begin
            f_ifid  = 1'b1;
            f_idrr  = 1'b1;
            f_rrex  = 1'b1;
            nxt     = FLUSH;
        end else if (state == STALL || haz_rr || haz_ex) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            bubble  = 1'b1;
            nxt     = (state == RUN && haz_rr) ? STALL : RUN;
        end else if (bus.id_jal) begin
            f_ifid  = 1'b1;
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= nxt;
    end

    assign bus.pc_en       = pc_en;
    assign bus.ifid_en     = ifid_en;
    assign bus.idrr_bubble = bubble;
    assign bus.flush_ifid  = f_ifid;
    assign bus.flush_idrr  = f_idrr;
    assign bus.flush_rrex  = f_rrex;
    assign bus.ctrl_state  = state;

`ifdef PIPE_HAZARD_PERF_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    // saturating counters of bubble cycles and branch-taken cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (bubble && stall_cnt != 16'hFFFF)          stall_cnt <= stall_cnt + 16'd1;
            if (bus.ex_br_taken && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
        end
    end

    assign bus.stall_cycles = stall_cnt;
    assign bus.flush_events = flush_cnt;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed test-plan steps then random traffic against a pending-work reference model
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    bit   stall_owed = 0;
    bit   flush_owed = 0;
    int   m_stalls = 0;
    int   m_flushes = 0;

    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.id_valid = 0; bus.id_src1 = 0; bus.id_src2 = 0; bus.id_jal = 0;
        bus.rr_valid = 0; bus.ex_valid = 0; bus.rr_dest = 0; bus.ex_dest = 0;
        bus.rr_wb_en = 0; bus.ex_wb_en = 0; bus.rr_mem_rd = 0; bus.ex_mem_rd = 0;
        bus.ex_br_taken = 0;
    endtask

    function automatic bit uses(input logic [3:0] src, input logic [2:0] d);
        return src[3] && src[2:0] == d;
    endfunction

    function automatic bit load_dep(input logic v, input logic wb, input logic ld, input logic [2:0] d);
        return bus.id_valid && v && wb && ld && (uses(bus.id_src1, d) || uses(bus.id_src2, d));
    endfunction

    // Model: owes at most one extra stall cycle or one follow-up flush cycle.
    task automatic step(input string tag);
        logic [5:0] ctl;
        logic [1:0] st;
        bit rr_dep, ex_dep;
        #2;
        rr_dep = load_dep(bus.rr_valid, bus.rr_wb_en, bus.rr_mem_rd, bus.rr_dest);
        ex_dep = load_dep(bus.ex_valid, bus.ex_wb_en, bus.ex_mem_rd, bus.ex_dest);
        st = flush_owed ? 2'b10 : stall_owed ? 2'b01 : 2'b00;
        if (reset) begin
            ctl = 6'b000111; stall_owed = 0; flush_owed = 0;
        end else if (flush_owed) begin
            ctl = 6'b110100; flush_owed = 0;
        end else if (bus.ex_br_taken) begin
            ctl = 6'b110111; flush_owed = 1; stall_owed = 0;
        end else if (stall_owed) begin
            ctl = 6'b001000; stall_owed = 0;
        end else if (rr_dep || ex_dep) begin
            ctl = 6'b001000; stall_owed = rr_dep;
        end else ctl = bus.id_jal ? 6'b110100 : 6'b110000;
        chk({tag, ".ctl"}, {2'b00, bus.pc_en, bus.ifid_en, bus.idrr_bubble, bus.flush_ifid, bus.flush_idrr, bus.flush_rrex}, {2'b00, ctl});
        chk({tag, ".state"}, {6'b0, bus.ctrl_state}, {6'b0, st});
`ifdef PIPE_HAZARD_PERF_EN
        chk({tag, ".stalls"}, bus.stall_cycles[7:0], m_stalls[7:0]);
        chk({tag, ".flushes"}, bus.flush_events[7:0], m_flushes[7:0]);
        if (reset) begin
            m_stalls = 0; m_flushes = 0;
        end else begin
            if (ctl[3] && m_stalls < 65535) m_stalls++;
            if (bus.ex_br_taken && m_flushes < 65535) m_flushes++;
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic rr_load3();
        bus.rr_valid = 1; bus.rr_dest = 3; bus.rr_wb_en = 1; bus.rr_mem_rd = 1;
    endtask

    task automatic ex_load3();
        bus.ex_valid = 1; bus.ex_dest = 3; bus.ex_wb_en = 1; bus.ex_mem_rd = 1;
    endtask

    initial begin
        idle();
        reset = 1;
        @(posedge clk);
        #1;
        step("reset");
        reset = 0;
        step("idle");
        idle(); bus.id_valid = 1; bus.id_src1 = 4'b1011; rr_load3();
        step("rr_stall1");
        idle(); bus.id_valid = 1; bus.id_src1 = 4'b1011; ex_load3();
        step("rr_stall2");
        idle(); bus.id_valid = 1; bus.id_src1 = 4'b1011;
        step("rr_release");
        idle(); bus.id_valid = 1; bus.id_src2 = 4'b1011; ex_load3();
        step("ex_stall");
        idle(); bus.id_valid = 1; bus.id_src2 = 4'b1011;
        step("ex_release");
        idle(); bus.id_valid = 1; bus.id_src1 = 4'b0011; rr_load3();
        step("src_unused");
        idle(); bus.id_valid = 1; bus.id_src1 = 4'b1011; rr_load3();
        step("stall_then_br");
        idle(); bus.ex_br_taken = 1;
        step("br_in_stall");
        idle(); bus.ex_br_taken = 1;
        step("flush_cycle");
        idle();
        step("after_flush");
        idle(); bus.id_valid = 1; bus.id_jal = 1;
        step("jal_run");
        idle(); bus.id_valid = 1; bus.id_src1 = 4'b1111; rr_load3(); bus.rr_dest = 7;
        step("r7_stall");
        idle(); bus.id_valid = 1; bus.id_jal = 1;
        step("jal_in_stall");
        idle(); bus.ex_br_taken = 1;
        step("br_run");
        idle(); reset = 1;
        step("reset_in_flush");
        reset = 0;
        step("post_reset");
        bus.id_valid = 1; bus.id_src1 = 4'b1011; rr_load3();
        step("perf_stall1");
        idle();
        step("perf_stall2");
        step("perf_after");
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 39) == 0);
            bus.id_valid = $urandom_range(0, 3) != 0;
            bus.id_src1 = 4'($urandom_range(0, 15)) & 4'b1011;
            bus.id_src2 = 4'($urandom_range(0, 15)) & 4'b1011;
            bus.id_jal = $urandom_range(0, 5) == 0;
            bus.rr_valid = $urandom_range(0, 1);
            bus.ex_valid = $urandom_range(0, 1);
            bus.rr_dest = 3'($urandom_range(0, 3));
            bus.ex_dest = 3'($urandom_range(0, 3));
            bus.rr_wb_en = $urandom_range(0, 3) != 0;
            bus.ex_wb_en = $urandom_range(0, 3) != 0;
            bus.rr_mem_rd = $urandom_range(0, 1);
            bus.ex_mem_rd = $urandom_range(0, 1);
            bus.ex_br_taken = $urandom_range(0, 7) == 0;
            step("random");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
